// File: rtl/lsu_multicycle_if.sv
// lsu_multicycle_if: bundles the execute-side request channel, the write-back
// response channel and the memory bus of the multicycle load/store unit.
//   master modport : the LSU itself (accepts requests, returns responses,
//                    masters the memory bus)
//   slave modport  : the environment (execute/write-back stages and memory)
// Request  : in_valid/in_ready, in_read, in_write, in_func3, in_addr, in_wdata
// Response : out_valid/out_ready, out_rdata, out_err
// Bus      : bus_req/bus_gnt, bus_we, bus_addr, bus_wdata, bus_wstrb,
//            bus_rvalid, bus_rdata
interface lsu_multicycle_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic                in_read;
  logic                in_write;
  logic [2:0]          in_func3;
  logic [ADDR_W-1:0]   in_addr;
  logic [XLEN-1:0]     in_wdata;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_rdata;
  logic                out_err;

  logic                bus_req;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [XLEN-1:0]     bus_wdata;
  logic [XLEN/8-1:0]   bus_wstrb;
  logic                bus_gnt;
  logic                bus_rvalid;
  logic [XLEN-1:0]     bus_rdata;

  modport master (
    input  in_valid, in_read, in_write, in_func3, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    output in_valid, in_read, in_write, in_func3, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_multicycle.sv
// lsu_multicycle: multi-cycle load/store unit. Accepts one load or store per
// in_valid/in_ready handshake, performs lane alignment, byte strobes and load
// extension, drives a req/gnt/rvalid memory bus, and returns exactly one
// response per request. Illegal or misaligned requests are answered with
// out_err without touching the bus; a stalled bus is cut off by a timeout.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   lsu - lsu_multicycle_if.master (request, response and bus channels)
module lsu_multicycle #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             rst,
  lsu_multicycle_if.master lsu
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic [CNT_W-1:0] cnt;

  logic             f3_ok;
  logic             misal;
  logic             illegal;
  logic             tmo;

  function automatic logic [NB-1:0] store_strb(input logic [1:0] sz,
                                               input logic [OFF_W-1:0] off);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return NB'(m) << off;
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend by funct3.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [2:0] f3,
                                               input logic [OFF_W-1:0] off);
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (f3)
      3'b000:  return XLEN'(b);
      3'b001:  return XLEN'(h);
      3'b010:  return XLEN'(w);
      3'b011:  return sh;
      3'b100:  return XLEN'(sh[7:0]);
      3'b101:  return XLEN'(sh[15:0]);
      3'b110:  return XLEN'(sh[31:0]);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    f3_ok = 1'b0;
    case (lsu.in_func3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = lsu.in_read;
      3'b011:                 f3_ok = (XLEN == 64);
      3'b110:                 f3_ok = lsu.in_read && (XLEN == 64);
      default:                f3_ok = 1'b0;
    endcase
    misal = 1'b0;
    case (lsu.in_func3[1:0])
      2'b01:   misal = lsu.in_addr[0];
      2'b10:   misal = |lsu.in_addr[1:0];
      2'b11:   misal = |lsu.in_addr[2:0];
      default: misal = 1'b0;
    endcase
    illegal = (lsu.in_read == lsu.in_write) || !f3_ok || misal;
  end

  assign tmo          = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC));
  assign lsu.in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      f3_q          <= '0;
      off_q         <= '0;
      cnt           <= '0;
      lsu.out_valid <= 1'b0;
      lsu.out_err   <= 1'b0;
      lsu.out_rdata <= '0;
      lsu.bus_req   <= 1'b0;
      lsu.bus_we    <= 1'b0;
      lsu.bus_addr  <= '0;
      lsu.bus_wdata <= '0;
      lsu.bus_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu.in_valid) begin
            f3_q  <= lsu.in_func3;
            off_q <= lsu.in_addr[OFF_W-1:0];
            if (illegal) begin
              state         <= RESP;
              lsu.out_valid <= 1'b1;
              lsu.out_err   <= 1'b1;
              lsu.out_rdata <= '0;
            end else begin
              state         <= REQ;
              cnt           <= '0;
              lsu.bus_req   <= 1'b1;
              lsu.bus_we    <= lsu.in_write;
              lsu.bus_addr  <= {lsu.in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              lsu.bus_wdata <= lsu.in_write ?
                               (lsu.in_wdata << {lsu.in_addr[OFF_W-1:0], 3'b000}) : '0;
              lsu.bus_wstrb <= lsu.in_write ?
                               store_strb(lsu.in_func3[1:0], lsu.in_addr[OFF_W-1:0]) : '0;
            end
          end
        end
        // Bus request phase: timeout wins over a grant in the same cycle.
        REQ: begin
          if (tmo) begin
            state         <= RESP;
            lsu.bus_req   <= 1'b0;
            lsu.out_valid <= 1'b1;
            lsu.out_err   <= 1'b1;
            lsu.out_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (lsu.bus_gnt) begin
              lsu.bus_req <= 1'b0;
              if (lsu.bus_we) begin
                state         <= RESP;
                lsu.out_valid <= 1'b1;
                lsu.out_err   <= 1'b0;
                lsu.out_rdata <= '0;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        // Read data phase: rvalid coincident with gnt was never looked at.
        WAIT: begin
          if (tmo) begin
            state         <= RESP;
            lsu.out_valid <= 1'b1;
            lsu.out_err   <= 1'b1;
            lsu.out_rdata <= '0;
          end else if (lsu.bus_rvalid) begin
            state         <= RESP;
            lsu.out_valid <= 1'b1;
            lsu.out_err   <= 1'b0;
            lsu.out_rdata <= load_ext(lsu.bus_rdata, f3_q, off_q);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Response phase: hold until consumed; no same-cycle re-accept.
        RESP: begin
          if (lsu.out_ready) begin
            state         <= IDLE;
            lsu.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_multicycle.sv
// tb_lsu_multicycle: directed bench for lsu_multicycle (XLEN=32,
// TIMEOUT_CYC=4). Inputs change on the falling edge, outputs are sampled on
// the falling edge before new inputs are applied, so a value "at cN" is the
// one seen on the falling edge after rising edge N-1 (accept edge = c0).
module tb_lsu_multicycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lsu_multicycle_if #(.XLEN(32), .ADDR_W(32)) bus_if ();

  lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bus_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("in_ready_idle", bus_if.in_ready, 1'b1);
    bus_if.in_valid = 1'b1;
    bus_if.in_read  = rd;
    bus_if.in_write = wr;
    bus_if.in_func3 = f3;
    bus_if.in_addr  = a;
    bus_if.in_wdata = wd;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_read  = 1'b0;
    bus_if.in_write = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, bus_if.out_valid, 1'b0);
  endtask

  // Load with grant at c1 and read data at c2; response expected at c3.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdat, input logic [31:0] exp);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    issue(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk);
    chk({tag, ".req"}, bus_if.bus_req, 1'b1);
    chk({tag, ".addr"}, bus_if.bus_addr, al);
    chk({tag, ".we"}, bus_if.bus_we, 1'b0);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    chk({tag, ".req_drop"}, bus_if.bus_req, 1'b0);
    chk({tag, ".early_valid"}, bus_if.out_valid, 1'b0);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = rdat;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    chk({tag, ".valid"}, bus_if.out_valid, 1'b1);
    chk({tag, ".rdata"}, bus_if.out_rdata, exp);
    chk({tag, ".err"}, bus_if.out_err, 1'b0);
    finish_resp(tag);
  endtask

  // Store with grant after gdly extra cycles of waiting.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gdly,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    issue(1'b0, 1'b1, f3, a, wd);
    for (int k = 0; k <= gdly; k++) begin
      @(negedge clk);
      chk({tag, ".req"}, bus_if.bus_req, 1'b1);
      chk({tag, ".we"}, bus_if.bus_we, 1'b1);
      chk({tag, ".addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      chk({tag, ".strb"}, bus_if.bus_wstrb, exp_strb);
      chk({tag, ".wdata"}, bus_if.bus_wdata, exp_wdata);
      chk({tag, ".no_valid"}, bus_if.out_valid, 1'b0);
    end
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    chk({tag, ".req_drop"}, bus_if.bus_req, 1'b0);
    chk({tag, ".valid"}, bus_if.out_valid, 1'b1);
    chk({tag, ".err"}, bus_if.out_err, 1'b0);
    chk({tag, ".rdata"}, bus_if.out_rdata, 32'h0);
    finish_resp(tag);
  endtask

  task automatic do_illegal(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
    issue(rd, wr, f3, a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, ".no_req"}, bus_if.bus_req, 1'b0);
    chk({tag, ".valid"}, bus_if.out_valid, 1'b1);
    chk({tag, ".err"}, bus_if.out_err, 1'b1);
    chk({tag, ".rdata"}, bus_if.out_rdata, 32'h0);
    chk({tag, ".in_ready"}, bus_if.in_ready, 1'b0);
    finish_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bus_if.in_valid   = 1'b0;
    bus_if.in_read    = 1'b0;
    bus_if.in_write   = 1'b0;
    bus_if.in_func3   = 3'b000;
    bus_if.in_addr    = '0;
    bus_if.in_wdata   = '0;
    bus_if.out_ready  = 1'b0;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.in_ready", bus_if.in_ready, 1'b0);
    chk("rst.out_valid", bus_if.out_valid, 1'b0);
    chk("rst.out_err", bus_if.out_err, 1'b0);
    chk("rst.out_rdata", bus_if.out_rdata, 32'h0);
    chk("rst.bus_req", bus_if.bus_req, 1'b0);
    chk("rst.bus_we", bus_if.bus_we, 1'b0);
    chk("rst.bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst.bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst.bus_wstrb", bus_if.bus_wstrb, 4'h0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_rel", bus_if.in_ready, 1'b1);

    // Loads with lane extraction and extension
    do_load("lw",   3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb3",  3'b000, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 32'h8000_0003, 32'h80FF_1234, 32'h0000_0080);
    do_load("lh2",  3'b001, 32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("lhu2", 3'b101, 32'h8000_0002, 32'h80FF_1234, 32'h0000_80FF);
    do_load("lb0",  3'b000, 32'h8000_0000, 32'h80FF_1234, 32'h0000_0034);
    do_load("lb1",  3'b000, 32'h8000_0001, 32'h80FF_9234, 32'hFFFF_FF92);

    // Stores: strobes and lane shift
    do_store("sh2", 3'b001, 32'h1000_0002, 32'h0000_ABCD, 3, 4'hC, 32'hABCD_0000);
    do_store("sb1", 3'b000, 32'h1000_0001, 32'h1234_56EF, 0, 4'h2, 32'h3456_EF00);
    do_store("sw0", 3'b010, 32'h1000_0008, 32'hCAFE_F00D, 1, 4'hF, 32'hCAFE_F00D);

    // rvalid coincident with gnt must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    @(negedge clk);
    bus_if.bus_gnt    = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hBADB_AD00;
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    chk("gntrv.no_valid", bus_if.out_valid, 1'b0);
    bus_if.bus_rdata  = 32'h1122_3344;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    chk("gntrv.valid", bus_if.out_valid, 1'b1);
    chk("gntrv.rdata", bus_if.out_rdata, 32'h1122_3344);
    finish_resp("gntrv");

    // Illegal requests
    do_illegal("lw_mis",  1'b1, 1'b0, 3'b010, 32'h8000_0002);
    do_illegal("rw_both", 1'b1, 1'b1, 3'b010, 32'h8000_0000);
    do_illegal("rw_none", 1'b0, 1'b0, 3'b010, 32'h8000_0000);
    do_illegal("f3_111",  1'b1, 1'b0, 3'b111, 32'h8000_0000);
    do_illegal("lh_mis",  1'b1, 1'b0, 3'b001, 32'h8000_0001);
    do_illegal("ld_x32",  1'b1, 1'b0, 3'b011, 32'h8000_0000);
    do_illegal("sbu",     1'b0, 1'b1, 3'b100, 32'h8000_0000);

    // Timeout: granted load with no rvalid; counter hits 4 at c5, response at c6
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    @(negedge clk);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("tmo.not_yet", bus_if.out_valid, 1'b0);
    @(negedge clk);
    chk("tmo.valid", bus_if.out_valid, 1'b1);
    chk("tmo.err", bus_if.out_err, 1'b1);
    chk("tmo.rdata", bus_if.out_rdata, 32'h0);
    chk("tmo.bus_req", bus_if.bus_req, 1'b0);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    chk("tmo.late_rdata", bus_if.out_rdata, 32'h0);
    chk("tmo.late_err", bus_if.out_err, 1'b1);
    finish_resp("tmo");
    bus_if.bus_rvalid = 1'b1;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    chk("tmo.idle_rv", bus_if.out_valid, 1'b0);
    do_load("after_tmo", 3'b010, 32'h8000_0024, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Response back-pressure
    issue(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0);
    @(negedge clk);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h0000_7FFE;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    held = 32'h0000_7FFE;
    for (int k = 0; k < 5; k++) begin
      chk("stall.valid", bus_if.out_valid, 1'b1);
      chk("stall.rdata", bus_if.out_rdata, held);
      chk("stall.err", bus_if.out_err, 1'b0);
      chk("stall.in_ready", bus_if.in_ready, 1'b0);
      @(negedge clk);
    end
    finish_resp("stall");

    // Reset while waiting for read data
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0030, 32'h0);
    @(negedge clk);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw.in_ready_low", bus_if.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw.bus_req", bus_if.bus_req, 1'b0);
    chk("rstw.out_valid", bus_if.out_valid, 1'b0);
    chk("rstw.in_ready", bus_if.in_ready, 1'b1);
    do_load("after_rst", 3'b000, 32'h8000_0002, 32'h0042_0000, 32'h0000_0042);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
